// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the divider issue controller: EX operation codes,
// controller states and the latched divide command.
package div_issue_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4,
    OP_MFHI = 3'd5,
    OP_MFLO = 3'd6
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Operands and signedness held toward the divider for one division.
  typedef struct packed {
    logic            is_signed;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } div_cmd_t;

  function automatic logic is_div_op(input ex_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_hilo.sv
// hilo_reg: architectural HI/LO register pair with the MFHI/MFLO read mux.
module hilo_reg
  import div_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] hi_wdata,
  input  logic [XLEN-1:0] lo_wdata,
  input  logic [2:0]      rd_op,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // NOTE: HI/LO are architectural state visible on hi/lo, so they get a real
  // reset value; a plain storage array would normally be left unreset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_wdata;
      if (lo_we) lo <= lo_wdata;
    end
  end

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    rdata = '0;
    case (ex_op_e'(rd_op))
      OP_MFHI: rdata = hi;
      OP_MFLO: rdata = lo;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Divider issue controller: IDLE/BUSY/DONE handshake with an iterative
// divider, pipeline stall generation and HI/LO update. Optional macro
// DIV_ZERO_SKIP_EN suppresses issue of divides with a zero divisor.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [2:0]      ex_op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            div_start,
  output logic            div_signed,
  output logic            div_annul,
  output logic [XLEN-1:0] div_op1,
  output logic [XLEN-1:0] div_op2,
  input  logic [63:0]     div_result,
  input  logic            div_ready,
  output logic            stall_o,
  output logic [XLEN-1:0] hilo_rdata,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  div_state_e      state_q, state_d;
  div_cmd_t        cmd_q;
  ex_op_e          op;
  logic            div_req;
  logic            zero_skip;
  logic            issue;
  logic            div_done;
  logic            div_kill;
  logic            mt_ok;
  logic            hi_we, lo_we;
  logic [XLEN-1:0] hi_wdata, lo_wdata;

  assign op      = ex_op_e'(ex_op);
  assign div_req = ex_valid && !flush && is_div_op(op);

`ifdef DIV_ZERO_SKIP_EN
  // A zero-divisor divide is dropped: no issue, no stall, HI/LO untouched.
  assign zero_skip = (rt_data == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Next state and the combinational stall. Flush beats div_ready in BUSY.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    div_done = 1'b0;
    div_kill = 1'b0;
    stall_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (div_req && !zero_skip) begin
          issue   = 1'b1;
          stall_o = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          div_kill = 1'b1;
          state_d  = ST_IDLE;
        end else if (div_ready) begin
          div_done = 1'b1;
          state_d  = ST_DONE;
        end else begin
          stall_o = 1'b1;
        end
      end
      ST_DONE: begin
        // Divider needs one free cycle; a new divide waits for IDLE.
        stall_o = div_req && !zero_skip;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      div_start <= 1'b0;
      div_annul <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_annul <= div_kill;
      if (issue) begin
        div_start       <= 1'b1;
        cmd_q.is_signed <= (op == OP_DIV);
        cmd_q.op1       <= rs_data;
        cmd_q.op2       <= rt_data;
      end else if (div_done || div_kill) begin
        div_start <= 1'b0;
      end
    end
  end

  assign div_signed = cmd_q.is_signed;
  assign div_op1    = cmd_q.op1;
  assign div_op2    = cmd_q.op2;

  // A completing divide owns both registers that cycle; moves only land
  // when the pipeline is actually advancing.
  always_comb begin
    mt_ok    = ex_valid && !flush && !stall_o;
    hi_we    = div_done || (mt_ok && (op == OP_MTHI));
    lo_we    = div_done || (mt_ok && (op == OP_MTLO));
    hi_wdata = div_done ? div_result[63:32] : rs_data;
    lo_wdata = div_done ? div_result[31:0]  : rs_data;
  end

  hilo_reg u_hilo (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .rd_op    (ex_op),
    .rdata    (hilo_rdata),
    .hi       (hi_o),
    .lo       (lo_o)
  );

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: flush  in  1  pipeline flush; kills the in-flight EX instruction.
REQ-004 SHALL have: ex_valid  in  1  EX instruction valid.
REQ-005 SHALL have: ex_op  in  3  operation: NOP, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-006 SHALL have: rs_data, rt_data  in  32 each  operands; dividend = rs, divisor = rt.
REQ-007 SHALL have: div_start, div_signed, div_annul  out  1 each  divider control.
REQ-008 SHALL have: div_op1, div_op2  out  32 each  latched operands to the divider.
REQ-009 SHALL have: div_result  in  64  {remainder, quotient}; div_ready  in  1.
REQ-010 SHALL have: stall_o  out  1  holds the pipeline.
REQ-011 SHALL have: hilo_rdata  out  32  MFHI/MFLO read data.
REQ-012 SHALL have: hi_o, lo_o  out  32 each  architectural HI and LO.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 IDLE: on ex_valid & (DIV|DIVU) & !flush, SHALL latch rs/rt into div_op1/div_op2, set div_signed (1 for DIV), assert div_start, and go to BUSY.
REQ-015 stall_o SHALL be combinationally 1 in the IDLE cycle that accepts a DIV/DIVU, so the pipeline holds from issue onward.
REQ-016 BUSY: div_start SHALL stay 1 and stall_o SHALL stay 1 until div_ready is sampled high.
REQ-017 BUSY & div_ready & !flush: SHALL write HI = div_result[63:32] and LO = div_result[31:0] at that edge, drop div_start, deassert stall_o the same cycle (combinational on div_ready), and go to DONE.
REQ-018 DONE: div_start SHALL be 0 for exactly one cycle so the divider returns to free. Any DIV/DIVU presented in DONE SHALL stall (stall_o=1) and issue only from IDLE on the next cycle.
REQ-019 flush in BUSY SHALL pulse div_annul=1 for one cycle, drop div_start, leave HI/LO unchanged, deassert stall_o, and go to IDLE. This holds even if div_ready is high in the same cycle; flush wins.
REQ-020 MTHI/MTLO SHALL write rs_data to HI/LO when ex_valid & !flush & !stall_o.
REQ-021 hilo_rdata SHALL be HI for MFHI, LO for MFLO, and 0 otherwise, combinationally from the registers.
REQ-022 ex_valid while stall_o=1 SHALL NOT cause a second issue or any HI/LO write.
REQ-023 div_op1/div_op2/div_signed SHALL remain stable from issue until leaving BUSY.

Reset
REQ-024 rst low SHALL asynchronously force: state IDLE; HI, LO, div_op1, div_op2 = 0; div_start, div_signed, div_annul, stall_o = 0.
REQ-025 Reset mid-division SHALL abandon the operation with no HI/LO update. The divider is reset by the same system reset.

Configuration
REQ-026 Macro DIV_ZERO_SKIP_EN: when defined, DIV/DIVU with rt_data==0 SHALL NOT issue, SHALL NOT stall, and SHALL leave HI/LO unchanged.
REQ-027 When DIV_ZERO_SKIP_EN is undefined, a zero divisor SHALL issue normally and HI/LO SHALL take the divider's result (64'h0).

Structure
REQ-028 The shared package SHALL hold the ex_op encodings and the state encodings IDLE/BUSY/DONE.
REQ-029 The HI/LO register pair plus its read mux SHALL be a sub-module named hilo_reg. The FSM stays in div_issue_ctrl.

Verification
REQ-030 DIV 100/7 -> stall_o high until div_ready, then HI=2, LO=14, with one DONE cycle where div_start=0.
REQ-031 DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> LO=0x7FFFFFFF, HI=1.
REQ-032 HI=LO=0x55, DIV issued, flush 5 cycles later -> div_annul pulses once, state IDLE, HI/LO remain 0x55.
REQ-033 Back-to-back DIVs: the second is held through DONE and issues from IDLE; both results are written in order, with div_start never high in DONE.
REQ-034 MTHI 0xDEADBEEF then MFHI -> hilo_rdata=0xDEADBEEF; MTLO presented while stall_o=1 -> LO unchanged.
REQ-035 DIV x/0 with DIV_ZERO_SKIP_EN -> no stall, HI/LO unchanged; without the macro -> stall until div_ready, then HI=LO=0.
